// File: rtl/mem_arb_if.sv
// mem_arb_if: groups the three source handshakes and the output handshake of
// the memory-controller output arbiter.
// Ports: sdram/flash/rom _valid/_data/_ready triplets, out_valid/out_ready/out_data/out_src.
// slave = arbiter side, master = sources plus consumer side.
interface mem_arb_if;
  logic       sdram_valid;
  logic [7:0] sdram_data;
  logic       sdram_ready;

  logic       flash_valid;
  logic [7:0] flash_data;
  logic       flash_ready;

  logic       rom_valid;
  logic [7:0] rom_data;
  logic       rom_ready;

  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] out_src;

  modport slave (
    input  sdram_valid, sdram_data,
    output sdram_ready,
    input  flash_valid, flash_data,
    output flash_ready,
    input  rom_valid, rom_data,
    output rom_ready,
    output out_valid, out_data, out_src,
    input  out_ready
  );

  modport master (
    output sdram_valid, sdram_data,
    input  sdram_ready,
    output flash_valid, flash_data,
    input  flash_ready,
    output rom_valid, rom_data,
    input  rom_ready,
    input  out_valid, out_data, out_src,
    output out_ready
  );
endinterface

// File: rtl/mem_arb.sv
// mem_arb: round-robin arbiter sharing one registered 8-bit output between the
// SDRAM (0), flash (1) and ROM (2) byte sources, with starvation override,
// request-pattern coverage counter and starvation bug flag.
// Ports: clock, reset (sync, active-high), bus (mem_arb_if.slave), coverage, bug.
// Latency: source handshake at N -> out_valid at N+1; one byte per 2 cycles peak.
module mem_arb #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       clock,
  input  logic       reset,
  mem_arb_if.slave   bus,
  output logic [3:0] coverage,
  output logic       bug
);

  localparam logic [2:0] StarveLim = 3'(STARVE_LIMIT);
  localparam logic [2:0] WaitMax   = 3'd7;
  localparam logic [1:0] SrcNone   = 2'd3;
  localparam logic [3:0] CovMax    = 4'd8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e state_q, state_d;

  // Source views as vectors so the selection logic can loop over them.
  logic [2:0] src_vld;
  logic [7:0] src_dat [3];
  logic [2:0] src_rdy;

  assign src_vld    = {bus.rom_valid, bus.flash_valid, bus.sdram_valid};
  assign src_dat[0] = bus.sdram_data;
  assign src_dat[1] = bus.flash_data;
  assign src_dat[2] = bus.rom_data;

  assign bus.sdram_ready = src_rdy[0];
  assign bus.flash_ready = src_rdy[1];
  assign bus.rom_ready   = src_rdy[2];

  // Registered state.
  logic [1:0]      ptr_q, ptr_d;
  logic [2:0][2:0] wait_q, wait_d;
  logic [7:0]      out_data_q, out_data_d;
  logic [1:0]      out_src_q, out_src_d;
  logic [7:0]      covmap_q, covmap_d;
  logic [3:0]      covsum_q, covsum_d;

  // Winner selection.
  logic [2:0] starve;
  logic [2:0] rr_cand;
  logic       win_vld;
  logic [1:0] win_idx;
  logic       grant;
  logic       out_vld;

  // Starved sources (waited STARVE_LIMIT or more) beat round-robin order,
  // lowest index first; otherwise scan ptr, ptr+1, ptr+2 modulo 3.
  always_comb begin : winner_sel
    starve  = '0;
    rr_cand = '0;
    win_vld = 1'b0;
    win_idx = 2'd0;
    for (int i = 0; i < 3; i++) begin
      starve[i] = src_vld[i] && (wait_q[i] >= StarveLim);
    end
    if (starve[0]) begin
      win_vld = 1'b1;
      win_idx = 2'd0;
    end else if (starve[1]) begin
      win_vld = 1'b1;
      win_idx = 2'd1;
    end else if (starve[2]) begin
      win_vld = 1'b1;
      win_idx = 2'd2;
    end else begin
      for (int k = 0; k < 3; k++) begin
        // 3-bit sum so ptr 2 + 2 does not wrap to 0 before the mod-3 fold.
        rr_cand = {1'b0, ptr_q} + 3'(k);
        if (rr_cand >= 3'd3) begin
          rr_cand = rr_cand - 3'd3;
        end
        if (!win_vld && src_vld[rr_cand[1:0]]) begin
          win_vld = 1'b1;
          win_idx = rr_cand[1:0];
        end
      end
    end
  end

  // FSM: state register.
  always_ff @(posedge clock) begin : fsm_state
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state.
  always_comb begin : fsm_next
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs. Only the winner sees ready, and only in IDLE outside reset,
  // so at most one source handshakes per cycle.
  always_comb begin : fsm_out
    src_rdy = '0;
    out_vld = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld && !reset) begin
          src_rdy[win_idx] = 1'b1;
        end
      end
      SEND: begin
        out_vld = 1'b1;
      end
      default: begin
        src_rdy = '0;
        out_vld = 1'b0;
      end
    endcase
  end

  assign grant = |src_rdy;

  // Datapath next state: capture, pointer, wait counters, coverage map.
  always_comb begin : dp_next
    ptr_d      = ptr_q;
    out_data_d = out_data_q;
    out_src_d  = out_src_q;
    covmap_d   = covmap_q;
    covsum_d   = covsum_q;
    wait_d     = wait_q;

    // A source waits while it is valid but not being accepted; dropping valid
    // or being accepted clears its count.
    for (int i = 0; i < 3; i++) begin
      if (!src_vld[i] || src_rdy[i]) begin
        wait_d[i] = 3'd0;
      end else if (wait_q[i] != WaitMax) begin
        wait_d[i] = wait_q[i] + 3'd1;
      end
    end

    if (state_q == IDLE) begin
      // Coverage samples the raw valid pattern on every IDLE cycle.
      if (!covmap_q[src_vld]) begin
        covmap_d[src_vld] = 1'b1;
        if (covsum_q != CovMax) begin
          covsum_d = covsum_q + 4'd1;
        end
      end
      if (grant) begin
        out_data_d = src_dat[win_idx];
        out_src_d  = win_idx;
        // Pointer follows the actual winner, even when starvation overrode it.
        ptr_d      = (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
      end
    end else if (bus.out_ready) begin
      out_src_d = SrcNone;
    end
  end

  // Datapath registers. Reset discards any held byte.
  always_ff @(posedge clock) begin : dp_regs
    if (reset) begin
      ptr_q      <= 2'd0;
      wait_q     <= '0;
      out_data_q <= 8'h00;
      out_src_q  <= SrcNone;
      covmap_q   <= 8'h00;
      covsum_q   <= 4'd0;
    end else begin
      ptr_q      <= ptr_d;
      wait_q     <= wait_d;
      out_data_q <= out_data_d;
      out_src_q  <= out_src_d;
      covmap_q   <= covmap_d;
      covsum_q   <= covsum_d;
    end
  end

  // Bug flag tracks the counters directly, so it rises the cycle a counter
  // hits 7 and falls the cycle after that counter clears.
  always_comb begin : bug_flag
    bug = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (wait_q[i] == WaitMax) begin
        bug = 1'b1;
      end
    end
  end

  assign bus.out_valid = out_vld;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign coverage      = covsum_q;

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed scenarios plus a randomized run against a cycle-level
// reference model of the arbitration rules.
// Inputs driven at posedge+1, outputs sampled at posedge+3.
module tb_mem_arb;

  localparam int STARVE = 4;

  logic       clock;
  logic       reset;
  logic [3:0] coverage;
  logic       bug;

  int checks = 0;
  int errors = 0;

  mem_arb_if bus ();

  mem_arb #(.STARVE_LIMIT(STARVE)) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .coverage (coverage),
    .bug      (bug)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state.
  bit         m_send;
  int         m_ptr;
  int         m_wait [3];
  bit [7:0]   m_cov;
  int         m_covsum;
  logic [7:0] m_data;
  int         m_src;

  function automatic logic [2:0] cur_vld();
    return {bus.rom_valid, bus.flash_valid, bus.sdram_valid};
  endfunction

  function automatic logic [2:0] cur_rdy();
    return {bus.rom_ready, bus.flash_ready, bus.sdram_ready};
  endfunction

  function automatic int m_winner();
    logic [2:0] v;
    v = cur_vld();
    if (reset || m_send) return -1;
    for (int i = 0; i < 3; i++)
      if (v[i] && m_wait[i] >= STARVE) return i;
    for (int k = 0; k < 3; k++)
      if (v[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
    return -1;
  endfunction

  function automatic logic [2:0] m_ready();
    int w;
    w = m_winner();
    if (w < 0) return 3'b000;
    return 3'(1 << w);
  endfunction

  function automatic logic m_bug();
    for (int i = 0; i < 3; i++)
      if (m_wait[i] == 7) return 1'b1;
    return 1'b0;
  endfunction

  task automatic set_in(input logic [2:0] v, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic ordy);
    bus.sdram_valid = v[0];
    bus.flash_valid = v[1];
    bus.rom_valid   = v[2];
    bus.sdram_data  = a;
    bus.flash_data  = b;
    bus.rom_data    = c;
    bus.out_ready   = ordy;
  endtask

  // Advance the model with the current inputs, then clock the DUT.
  task automatic tick();
    int w;
    logic [2:0] v;
    logic [7:0] d [3];
    v = cur_vld();
    d[0] = bus.sdram_data;
    d[1] = bus.flash_data;
    d[2] = bus.rom_data;
    if (reset) begin
      m_send = 0; m_ptr = 0; m_cov = '0; m_covsum = 0; m_data = 8'h00; m_src = 3;
      for (int i = 0; i < 3; i++) m_wait[i] = 0;
    end else begin
      w = m_winner();
      for (int i = 0; i < 3; i++) begin
        if (!v[i] || i == w) m_wait[i] = 0;
        else if (m_wait[i] < 7) m_wait[i] = m_wait[i] + 1;
      end
      if (!m_send) begin
        if (!m_cov[v]) begin
          m_cov[v] = 1'b1;
          if (m_covsum < 8) m_covsum = m_covsum + 1;
        end
        if (w >= 0) begin
          m_data = d[w]; m_src = w; m_ptr = (w + 1) % 3; m_send = 1;
        end
      end else if (bus.out_ready) begin
        m_src = 3; m_send = 0;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    set_in(3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < n; i++) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(3'b111, 8'h11, 8'h22, 8'h33, 1'b1);
    #2;
    checks++;
    if (cur_rdy() !== 3'b000) begin
      errors++; $display("FAIL reset_rdy_in_reset got %b exp 000", cur_rdy());
    end
    tick();
    set_in(3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
    tick();
    reset = 1'b0;
    #2;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid);
    end
    checks++;
    if (bus.out_src !== 2'd3) begin
      errors++; $display("FAIL reset_out_src got %0d exp 3", bus.out_src);
    end
    checks++;
    if (bus.out_data !== 8'h00) begin
      errors++; $display("FAIL reset_out_data got %h exp 00", bus.out_data);
    end
    checks++;
    if (cur_rdy() !== 3'b000) begin
      errors++; $display("FAIL reset_rdy got %b exp 000", cur_rdy());
    end
    checks++;
    if (coverage !== 4'd0 || bug !== 1'b0) begin
      errors++; $display("FAIL reset_cov_bug got %0d/%b exp 0/0", coverage, bug);
    end
  endtask

  task automatic test_single();
    do_reset(2);
    set_in(3'b010, 8'h11, 8'hA5, 8'h22, 1'b1);
    #2;
    checks++;
    if (cur_rdy() !== 3'b010) begin
      errors++; $display("FAIL single_rdy got %b exp 010", cur_rdy());
    end
    tick();
    set_in(3'b000, 8'h00, 8'h00, 8'h00, 1'b1);
    #2;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5 || bus.out_src !== 2'd1) begin
      errors++; $display("FAIL single_out got v%b d%h s%0d exp v1 dA5 s1",
                         bus.out_valid, bus.out_data, bus.out_src);
    end
    tick();
    #2;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_src !== 2'd3) begin
      errors++; $display("FAIL single_idle got v%b s%0d exp v0 s3", bus.out_valid, bus.out_src);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] d [3];
    logic [7:0] exp_d;
    int         g;
    do_reset(1);
    exp_d = 8'h00;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < 3; i++) d[i] = 8'($urandom_range(255));
      set_in(3'b111, d[0], d[1], d[2], 1'b1);
      #2;
      g = (c / 2) % 3;
      if (c % 2 == 0) begin
        checks++;
        if (cur_rdy() !== 3'(1 << g)) begin
          errors++; $display("FAIL rr_rdy cyc %0d got %b exp %b", c, cur_rdy(), 3'(1 << g));
        end
        exp_d = d[g];
      end else begin
        checks++;
        if (cur_rdy() !== 3'b000 || bus.out_valid !== 1'b1 || bus.out_data !== exp_d ||
            bus.out_src !== 2'(g)) begin
          errors++; $display("FAIL rr_out cyc %0d got r%b v%b d%h s%0d exp r000 v1 d%h s%0d",
                             c, cur_rdy(), bus.out_valid, bus.out_data, bus.out_src, exp_d, g);
        end
      end
      tick();
    end
  endtask

  task automatic test_starvation();
    do_reset(1);
    set_in(3'b111, 8'h5A, 8'h6B, 8'h7C, 1'b0);
    #2;
    checks++;
    if (cur_rdy() !== 3'b001) begin
      errors++; $display("FAIL starve_first got %b exp 001", cur_rdy());
    end
    tick();
    for (int k = 1; k <= 8; k++) begin
      set_in(3'b110, 8'h00, 8'h6B, 8'h7C, 1'b0);
      #2;
      checks++;
      if (bus.out_valid !== 1'b1 || cur_rdy() !== 3'b000 || bug !== (k >= 7)) begin
        errors++; $display("FAIL starve_stall k %0d got v%b r%b bug%b exp v1 r000 bug%b",
                           k, bus.out_valid, cur_rdy(), bug, (k >= 7));
      end
      tick();
    end
    set_in(3'b110, 8'h00, 8'h6B, 8'h7C, 1'b1);
    tick();
    #2;
    checks++;
    if (cur_rdy() !== 3'b010) begin
      errors++; $display("FAIL starve_flash got %b exp 010", cur_rdy());
    end
    tick();
    #2;
    checks++;
    if (bug !== 1'b1 || bus.out_src !== 2'd1 || bus.out_data !== 8'h6B) begin
      errors++; $display("FAIL starve_send1 got bug%b s%0d d%h exp bug1 s1 d6B",
                         bug, bus.out_src, bus.out_data);
    end
    tick();
    #2;
    checks++;
    if (cur_rdy() !== 3'b100) begin
      errors++; $display("FAIL starve_rom got %b exp 100", cur_rdy());
    end
    tick();
    #2;
    checks++;
    if (bug !== 1'b0 || bus.out_src !== 2'd2 || bus.out_data !== 8'h7C) begin
      errors++; $display("FAIL starve_clear got bug%b s%0d d%h exp bug0 s2 d7C",
                         bug, bus.out_src, bus.out_data);
    end
    tick();
  endtask

  task automatic test_coverage();
    logic [2:0] pats [10];
    int         exps [10];
    pats = '{3'b000, 3'b001, 3'b001, 3'b111, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    exps = '{1, 2, 2, 3, 4, 5, 6, 7, 8, 8};
    do_reset(1);
    for (int i = 0; i < 10; i++) begin
      set_in(pats[i], 8'($urandom_range(255)), 8'($urandom_range(255)),
             8'($urandom_range(255)), 1'b1);
      tick();
      #2;
      checks++;
      if (coverage !== 4'(exps[i])) begin
        errors++; $display("FAIL cov step %0d got %0d exp %0d", i, coverage, exps[i]);
      end
      if (pats[i] != 3'b000) begin
        set_in(3'b000, 8'h00, 8'h00, 8'h00, 1'b1);
        tick();
      end
    end
  endtask

  task automatic test_mid_send_reset();
    do_reset(1);
    set_in(3'b100, 8'h01, 8'h02, 8'h3C, 1'b0);
    tick();
    set_in(3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
    #2;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h3C || bus.out_src !== 2'd2) begin
      errors++; $display("FAIL msr_held got v%b d%h s%0d exp v1 d3C s2",
                         bus.out_valid, bus.out_data, bus.out_src);
    end
    reset = 1'b1;
    set_in(3'b111, 8'h01, 8'h02, 8'h03, 1'b0);
    tick();
    reset = 1'b0;
    set_in(3'b111, 8'h01, 8'h02, 8'h03, 1'b1);
    #2;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_src !== 2'd3) begin
      errors++; $display("FAIL msr_cleared got v%b d%h s%0d exp v0 d00 s3",
                         bus.out_valid, bus.out_data, bus.out_src);
    end
    checks++;
    if (cur_rdy() !== 3'b001) begin
      errors++; $display("FAIL msr_regrant got %b exp 001", cur_rdy());
    end
    tick();
  endtask

  task automatic test_random();
    logic [2:0] v;
    logic [3:0] exp_src;
    do_reset(1);
    for (int c = 0; c < 800; c++) begin
      reset = ($urandom_range(79) == 0);
      v = 3'($urandom_range(7));
      set_in(v, 8'($urandom_range(255)), 8'($urandom_range(255)), 8'($urandom_range(255)),
             ($urandom_range(9) < 6));
      #2;
      exp_src = 4'(m_src);
      checks++;
      if (cur_rdy() !== m_ready() || bus.out_valid !== m_send || bus.out_data !== m_data ||
          bus.out_src !== exp_src[1:0] || coverage !== 4'(m_covsum) || bug !== m_bug()) begin
        errors++;
        $display("FAIL rand cyc %0d got r%b v%b d%h s%0d c%0d b%b exp r%b v%b d%h s%0d c%0d b%b",
                 c, cur_rdy(), bus.out_valid, bus.out_data, bus.out_src, coverage, bug,
                 m_ready(), m_send, m_data, m_src, m_covsum, m_bug());
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    set_in(3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
    m_send = 0; m_ptr = 0; m_cov = '0; m_covsum = 0; m_data = 8'h00; m_src = 3;
    for (int i = 0; i < 3; i++) m_wait[i] = 0;
    @(posedge clock);
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_starvation();
    test_coverage();
    test_mid_send_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
